// File: rtl/scan_chain_controller.sv
// scan_chain_controller: drives an external mux-D scan chain. Each operation
// shifts a latched pattern in, pulses one functional capture cycle, and then
// shifts the chain contents back out into CapData.
// Optional feature: define SCAN_CMP_EN to latch ExpIn and register a
// CapData == ExpIn compare into Pass on DONE entry; otherwise Pass is 0.
module scan_chain_controller #(
  parameter  int CHAIN_LEN = 4,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 ScanClk,
  input  logic                 ScanClr,
  input  logic                 Start,
  input  logic [CHAIN_LEN-1:0] PatIn,
  input  logic [CHAIN_LEN-1:0] ExpIn,
  input  logic                 ScanOut,
  output logic                 ScanMode,
  output logic                 ScanIn,
  output logic                 Busy,
  output logic                 Done,
  output logic [CHAIN_LEN-1:0] CapData,
  output logic                 Pass
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] MSB_BIT  = CHAIN_LEN'(1) << (CHAIN_LEN - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_sr;   // remaining pattern bits, next bit at the top
  logic [CHAIN_LEN-1:0] cap_sr;   // bits gathered so far in SHIFT_OUT
  logic [CHAIN_LEN-1:0] cap_nxt;
  logic                 last;

  assign last = (cnt == CNT_LAST);

  // each ScanOut bit enters at the top, so the first bit seen ends up in bit 0
  always_comb begin
    cap_nxt = (cap_sr >> 1) | (ScanOut ? MSB_BIT : '0);
  end

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;

  // expected capture is latched at accept and compared once on DONE entry
  always_ff @(posedge ScanClk or posedge ScanClr) begin
    if (ScanClr) begin
      exp_q <= '0;
      Pass  <= 1'b0;
    end else if (state == IDLE && Start) begin
      exp_q <= ExpIn;
    end else if (state == SHIFT_OUT && last) begin
      Pass  <= (cap_nxt == exp_q);
    end
  end
`else
  logic unused_exp;
  assign unused_exp = ^ExpIn;
  assign Pass       = 1'b0;
`endif

  // operation sequencer; every output is set on the edge that enters its phase
  always_ff @(posedge ScanClk or posedge ScanClr) begin
    if (ScanClr) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_sr   <= '0;
      cap_sr   <= '0;
      ScanMode <= 1'b0;
      ScanIn   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      CapData  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= SHIFT_IN;
            cnt      <= '0;
            ScanMode <= 1'b1;
            ScanIn   <= PatIn[CHAIN_LEN-1];
            pat_sr   <= PatIn << 1;
            Busy     <= 1'b1;
          end
        end
        SHIFT_IN: begin
          if (last) begin
            state    <= CAPTURE;
            cnt      <= '0;
            ScanMode <= 1'b0;
            ScanIn   <= 1'b0;
          end else begin
            cnt    <= cnt + 1'b1;
            ScanIn <= pat_sr[CHAIN_LEN-1];
            pat_sr <= pat_sr << 1;
          end
        end
        CAPTURE: begin
          state    <= SHIFT_OUT;
          cnt      <= '0;
          ScanMode <= 1'b1;
          ScanIn   <= 1'b0;
        end
        SHIFT_OUT: begin
          cap_sr <= cap_nxt;
          if (last) begin
            state    <= DONE;
            cnt      <= '0;
            ScanMode <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            CapData  <= cap_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ScanMode <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller with CHAIN_LEN=4 and a 4-flop chain model
// that loads a programmable constant whenever ScanMode is low.
module tb_scan_chain_controller;
  localparam int L = 4;

  logic         ScanClk = 1'b0;
  logic         ScanClr;
  logic         Start;
  logic [L-1:0] PatIn, ExpIn;
  logic         ScanOut;
  logic         ScanMode, ScanIn, Busy, Done, Pass;
  logic [L-1:0] CapData;

  logic [L-1:0] chain;
  logic [L-1:0] cap_const;
  int           n_chk  = 0;
  int           n_fail = 0;

  scan_chain_controller #(.CHAIN_LEN(L)) dut (
    .ScanClk(ScanClk), .ScanClr(ScanClr), .Start(Start), .PatIn(PatIn),
    .ExpIn(ExpIn), .ScanOut(ScanOut), .ScanMode(ScanMode), .ScanIn(ScanIn),
    .Busy(Busy), .Done(Done), .CapData(CapData), .Pass(Pass)
  );

  always #5 ScanClk = ~ScanClk;

  // external chain: ScanIn enters at the top, flop 0 drives ScanOut
  always @(posedge ScanClk) chain <= ScanMode ? {ScanIn, chain[L-1:1]} : cap_const;
  assign ScanOut = chain[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic exp_pass(input logic [L-1:0] cap, input logic [L-1:0] e);
`ifdef SCAN_CMP_EN
    return cap == e;
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: plain op, 1: Start re-pulse + PatIn/ExpIn change in SHIFT_IN,
  // 2: ScanClr in SHIFT_OUT cycle 2. Called at a negedge with the DUT idle.
  task automatic run_op(input logic [L-1:0] pat, input logic [L-1:0] e,
                        input logic [L-1:0] cap, input int mode);
    logic [L-1:0] got_in;
    got_in    = '0;
    cap_const = cap;
    PatIn     = pat;
    ExpIn     = e;
    Start     = 1'b1;
    @(negedge ScanClk);
    Start = 1'b0;
    if (mode == 1) begin
      PatIn = ~pat;
      ExpIn = ~e;
    end
    for (int k = 0; k < L; k++) begin
      chk("sin_mode", ScanMode, 1'b1);
      chk("sin_busy", Busy, 1'b1);
      got_in[L-1-k] = ScanIn;
      if (mode == 1) Start = (k == 1);
      @(negedge ScanClk);
    end
    Start = 1'b0;
    chk("sin_bits", got_in, pat);
    chk("cap_mode", ScanMode, 1'b0);
    chk("cap_sin", ScanIn, 1'b0);
    chk("cap_busy", Busy, 1'b1);
    @(negedge ScanClk);
    for (int k = 0; k < L; k++) begin
      chk("sout_mode", ScanMode, 1'b1);
      chk("sout_sin", ScanIn, 1'b0);
      if (mode == 2 && k == 2) begin
        #1 ScanClr = 1'b1;
        #1;
        chk("abort_mode", ScanMode, 1'b0);
        chk("abort_cap", CapData, '0);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_pass", Pass, 1'b0);
        @(negedge ScanClk);
        ScanClr = 1'b0;
        for (int c = 0; c < 3 * L; c++) begin
          chk("abort_nodone", Done, 1'b0);
          @(negedge ScanClk);
        end
        return;
      end
      @(negedge ScanClk);
    end
    chk("done", Done, 1'b1);
    chk("done_busy", Busy, 1'b0);
    chk("done_mode", ScanMode, 1'b0);
    chk("capdata", CapData, cap);
    chk("pass", Pass, exp_pass(cap, e));
    @(negedge ScanClk);
    chk("done_pulse", Done, 1'b0);
    chk("cap_hold", CapData, cap);
    chk("pass_hold", Pass, exp_pass(cap, e));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end

  initial begin
    int done_t[$];
    int low;
    bit seen_busy;
    bit got_done;
    logic [L-1:0] p, c, e;

    ScanClr   = 1'b1;
    Start     = 1'b0;
    PatIn     = '0;
    ExpIn     = '0;
    cap_const = '0;
    #1;
    chk("rst_mode", ScanMode, 1'b0);
    chk("rst_sin", ScanIn, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_cap", CapData, '0);
    chk("rst_pass", Pass, 1'b0);
    repeat (3) @(negedge ScanClk);
    ScanClr = 1'b0;
    @(negedge ScanClk);

    // reset asserted mid SHIFT_IN clears everything at once
    PatIn = 4'b1111;
    Start = 1'b1;
    @(negedge ScanClk);
    Start = 1'b0;
    @(negedge ScanClk);
    chk("pre_clr_mode", ScanMode, 1'b1);
    #1 ScanClr = 1'b1;
    #1;
    chk("clr_mode", ScanMode, 1'b0);
    chk("clr_sin", ScanIn, 1'b0);
    chk("clr_busy", Busy, 1'b0);
    chk("clr_done", Done, 1'b0);
    chk("clr_cap", CapData, '0);
    chk("clr_pass", Pass, 1'b0);
    @(negedge ScanClk);
    ScanClr = 1'b0;
    @(negedge ScanClk);

    // basic pattern and compare cases
    run_op(4'b1010, 4'b0110, 4'b0110, 0);
    run_op(4'b1010, 4'b0111, 4'b0110, 0);
    // changes and Start during SHIFT_IN are ignored
    run_op(4'b1100, 4'b1001, 4'b1001, 1);
    // abort in SHIFT_OUT, then a normal op
    run_op(4'b0011, 4'b1110, 4'b1110, 2);
    run_op(4'b0101, 4'b1011, 4'b1011, 0);

    // Start held high: period and Busy-low gap
    cap_const = 4'b1101;
    PatIn     = 4'b0110;
    Start     = 1'b1;
    low       = 0;
    seen_busy = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge ScanClk);
      if (Done) done_t.push_back(cyc);
      if (!Busy) low++;
      else begin
        if (seen_busy && low > 0) chk("b2b_busy_low", low, 2);
        low       = 0;
        seen_busy = 1'b1;
      end
    end
    Start = 1'b0;
    chk("b2b_count", done_t.size() >= 4, 1'b1);
    for (int i = 1; i < done_t.size(); i++)
      chk("b2b_period", done_t[i] - done_t[i-1], 2 * L + 3);
    got_done = 1'b0;
    for (int cyc = 0; cyc < 4 * L && !got_done; cyc++) begin
      @(negedge ScanClk);
      if (Done) got_done = 1'b1;
    end
    chk("b2b_drain", got_done, 1'b1);
    @(negedge ScanClk);
    chk("b2b_idle", Busy, 1'b0);

    // randomized operations
    for (int n = 0; n < 20; n++) begin
      p = L'($urandom);
      c = L'($urandom);
      e = ($urandom_range(0, 1) != 0) ? c : L'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge ScanClk);
      run_op(p, e, c, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
